// File: rtl/snn_seq_pkg.sv
// -----------------------------------------------------------------------------
// snn_seq_pkg
// Shared types and constants for the spiking-network trial sequencer.
//   seq_state_e  : trial sequencer phases (IDLE, LOAD, CLEAR, RUN, SAMPLE)
//   CMD_*        : network command encodings (RUN, NOP, CLEAR)
//   cfg_entry_t  : one configuration-table entry {addr, cmd, arg}, which is
//                  also the value carried on the network configuration bus
// Entry field widths are fixed here.  The sequencer's ADDR_WIDTH, CMD_WIDTH
// and FLOAT_WIDTH parameters default to the same values and must match them.
// -----------------------------------------------------------------------------
package snn_seq_pkg;

  localparam int PKG_ADDR_WIDTH  = 3;
  localparam int PKG_CMD_WIDTH   = 3;
  localparam int PKG_FLOAT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_RUN    = 3'd3,
    ST_SAMPLE = 3'd4
  } seq_state_e;

  localparam logic [PKG_CMD_WIDTH-1:0] CMD_RUN   = PKG_CMD_WIDTH'(0);
  localparam logic [PKG_CMD_WIDTH-1:0] CMD_NOP   = PKG_CMD_WIDTH'(1);
  localparam logic [PKG_CMD_WIDTH-1:0] CMD_CLEAR = PKG_CMD_WIDTH'((2 ** PKG_CMD_WIDTH) - 3);

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0]  addr;
    logic [PKG_CMD_WIDTH-1:0]   cmd;
    logic [PKG_FLOAT_WIDTH-1:0] arg;
  } cfg_entry_t;

  // Fixed bus values. Address 0 selects no neuron.
  localparam cfg_entry_t IDLE_ENTRY  = '{addr: '0, cmd: CMD_NOP,   arg: '0};
  localparam cfg_entry_t CLEAR_ENTRY = '{addr: '0, cmd: CMD_CLEAR, arg: '0};
  localparam cfg_entry_t RUN_ENTRY   = '{addr: '0, cmd: CMD_RUN,   arg: '0};

endpackage

// File: rtl/snn_trial_sequencer_if.sv
// -----------------------------------------------------------------------------
// snn_trial_sequencer_if
// Connection between the trial sequencer and one spiking XOR network.
//   net_addr / net_cmd / net_cmd_arg : configuration bus (sequencer -> network)
//   net_in1 / net_in2                : network argument inputs (sequencer -> network)
//   net_out                          : network decision (network -> sequencer)
//   net_out_time                     : network decision time (network -> sequencer)
// Modports: master = sequencer side, slave = network side.
// -----------------------------------------------------------------------------
interface snn_trial_sequencer_if #(
  parameter int ADDR_WIDTH  = 3,
  parameter int CMD_WIDTH   = 3,
  parameter int FLOAT_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]  net_addr;
  logic [CMD_WIDTH-1:0]   net_cmd;
  logic [FLOAT_WIDTH-1:0] net_cmd_arg;
  logic                   net_in1;
  logic                   net_in2;
  logic                   net_out;
  logic [31:0]            net_out_time;

  modport master (
    output net_addr, net_cmd, net_cmd_arg, net_in1, net_in2,
    input  net_out, net_out_time
  );

  modport slave (
    input  net_addr, net_cmd, net_cmd_arg, net_in1, net_in2,
    output net_out, net_out_time
  );

endinterface

// File: rtl/snn_cfg_table.sv
// -----------------------------------------------------------------------------
// snn_cfg_table
// CFG_DEPTH-entry register file of cfg_entry_t. Contents are not reset, so a
// table written once survives sequencer resets.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_idx_i   : write index
//   wr_data_i  : write data
//   rd_idx_i   : read index
//   rd_data_o  : read data (combinational)
// -----------------------------------------------------------------------------
module snn_cfg_table
  import snn_seq_pkg::*;
#(
  parameter int CFG_DEPTH = 16,
  parameter int IDX_WIDTH = $clog2(CFG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  cfg_entry_t           wr_data_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output cfg_entry_t           rd_data_o
);

  cfg_entry_t mem_q [CFG_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_idx_i) < CFG_DEPTH)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational read: the sequencer needs entry i on the bus the cycle
  // right after it decides to send it.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/snn_trial_sequencer.sv
// -----------------------------------------------------------------------------
// snn_trial_sequencer
// Replays a configuration table into a spiking XOR network, issues one CLEAR,
// runs the network for RUN_CYCLES cycles, then captures its decision.
//   clk, rst        : clock, synchronous active-high reset
//   start           : trial request (IDLE only); latches in1, in2, cfg_len
//   in1, in2        : trial arguments
//   cfg_len         : entries to replay (clamped to CFG_DEPTH)
//   cfg_we/idx/addr/cmd/arg : table write port (accepted only when idle)
//   cfg_rej         : one-cycle pulse after a dropped table write
//   busy            : trial in progress, through the res_valid cycle
//   res_valid       : one-cycle result strobe
//   res_out         : captured decision (1 only for a clean 1 from the network)
//   res_time        : captured decision time
//   net             : network bus (interface, master side), all outputs registered
// Optional feature: define SNN_SEQ_SKIP_RELOAD_EN to skip the LOAD phase when
// the table and length are unchanged since the last replay.
// -----------------------------------------------------------------------------
module snn_trial_sequencer
  import snn_seq_pkg::*;
#(
  parameter int INT_WIDTH   = 4,
  parameter int FLOAT_WIDTH = 2 * INT_WIDTH,
  parameter int ADDR_WIDTH  = 3,
  parameter int CMD_WIDTH   = 3,
  parameter int CFG_DEPTH   = 16,
  parameter int IDX_WIDTH   = $clog2(CFG_DEPTH),
  parameter int RUN_CYCLES  = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in1,
  input  logic                   in2,
  input  logic [IDX_WIDTH:0]     cfg_len,
  input  logic                   cfg_we,
  input  logic [IDX_WIDTH-1:0]   cfg_idx,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [CMD_WIDTH-1:0]   cfg_cmd,
  input  logic [FLOAT_WIDTH-1:0] cfg_arg,
  output logic                   cfg_rej,
  output logic                   busy,
  output logic                   res_valid,
  output logic                   res_out,
  output logic [31:0]            res_time,
  snn_trial_sequencer_if.master  net
);

  localparam int RUN_CNT_WIDTH = $clog2(RUN_CYCLES + 1);
  localparam logic [RUN_CNT_WIDTH-1:0] RUN_LAST  = RUN_CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [IDX_WIDTH:0]       LEN_MAX   = (IDX_WIDTH + 1)'(CFG_DEPTH);
  localparam logic [IDX_WIDTH:0]       LEN_ONE   = (IDX_WIDTH + 1)'(1);
  localparam logic [IDX_WIDTH-1:0]     IDX_ONE   = IDX_WIDTH'(1);

  seq_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [IDX_WIDTH:0]       len_q, len_d;
  logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic                     in1_q, in1_d;
  logic                     in2_q, in2_d;
  cfg_entry_t               bus_q, bus_d;
  logic                     res_valid_q, res_valid_d;
  logic                     res_out_q, res_out_d;
  logic [31:0]              res_time_q, res_time_d;
  logic                     cfg_rej_q, cfg_rej_d;

  logic                     idle_ready;
  logic                     start_acc;
  logic                     wr_acc;
  logic [IDX_WIDTH:0]       eff_len;
  logic                     load_needed;
  logic [IDX_WIDTH:0]       next_idx_ext;
  logic [IDX_WIDTH-1:0]     rd_idx;
  cfg_entry_t               rd_data;
  cfg_entry_t               wr_data;

  // The res_valid cycle still counts as busy, so the first cycle that can
  // accept a start or a table write is the one after it.
  assign idle_ready = (state_q == ST_IDLE) && !res_valid_q;
  assign start_acc  = idle_ready && start;
  assign wr_acc     = idle_ready && cfg_we && !start;

  assign eff_len      = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign next_idx_ext = {1'b0, idx_q} + LEN_ONE;

  // Look one entry ahead: the bus register is loaded with the entry that
  // will sit on the bus during the next cycle.
  assign rd_idx = (state_q == ST_IDLE) ? '0 : (idx_q + IDX_ONE);

  assign wr_data = '{addr: cfg_addr, cmd: cfg_cmd, arg: cfg_arg};

  snn_cfg_table #(
    .CFG_DEPTH (CFG_DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_cfg_table (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_idx_i  (cfg_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

`ifdef SNN_SEQ_SKIP_RELOAD_EN
  logic               dirty_q, dirty_d;
  logic [IDX_WIDTH:0] last_len_q, last_len_d;
  logic               reload_dirty;

  // A new length counts as a table change; the network would otherwise keep
  // entries from a longer previous replay or miss entries of a longer one.
  assign reload_dirty = dirty_q || (eff_len != last_len_q);
  assign load_needed  = reload_dirty && (eff_len != '0);
`else
  assign load_needed  = (eff_len != '0);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    run_cnt_d   = run_cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    bus_d       = IDLE_ENTRY;
    res_valid_d = 1'b0;
    res_out_d   = res_out_q;
    res_time_d  = res_time_q;
    cfg_rej_d   = cfg_we && !wr_acc;
`ifdef SNN_SEQ_SKIP_RELOAD_EN
    dirty_d     = dirty_q || wr_acc;
    last_len_d  = last_len_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          in1_d = in1;
          in2_d = in2;
          len_d = eff_len;
          idx_d = '0;
`ifdef SNN_SEQ_SKIP_RELOAD_EN
          dirty_d = reload_dirty;
`endif
          if (load_needed) begin
            state_d = ST_LOAD;
            bus_d   = rd_data;
          end else begin
            state_d = ST_CLEAR;
            bus_d   = CLEAR_ENTRY;
          end
        end
      end

      ST_LOAD: begin
        if (next_idx_ext < len_q) begin
          idx_d = idx_q + IDX_ONE;
          bus_d = rd_data;
        end else begin
          state_d = ST_CLEAR;
          bus_d   = CLEAR_ENTRY;
`ifdef SNN_SEQ_SKIP_RELOAD_EN
          dirty_d    = 1'b0;
          last_len_d = len_q;
`endif
        end
      end

      ST_CLEAR: begin
        state_d   = ST_RUN;
        run_cnt_d = '0;
        bus_d     = RUN_ENTRY;
      end

      ST_RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_CNT_WIDTH'(1);
          bus_d     = RUN_ENTRY;
        end
      end

      ST_SAMPLE: begin
        // X or Z from the network is reported as "no decision".
        res_out_d   = (net.net_out === 1'b1);
        res_time_d  = net.net_out_time;
        res_valid_d = 1'b1;
        in1_d       = 1'b0;
        in2_d       = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      run_cnt_q   <= '0;
      in1_q       <= 1'b0;
      in2_q       <= 1'b0;
      bus_q       <= IDLE_ENTRY;
      res_valid_q <= 1'b0;
      res_out_q   <= 1'b0;
      res_time_q  <= '0;
      cfg_rej_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      run_cnt_q   <= run_cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      bus_q       <= bus_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_time_q  <= res_time_d;
      cfg_rej_q   <= cfg_rej_d;
    end
  end

`ifdef SNN_SEQ_SKIP_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q    <= 1'b1;
      last_len_q <= '0;
    end else begin
      dirty_q    <= dirty_d;
      last_len_q <= last_len_d;
    end
  end
`endif

  assign net.net_addr    = bus_q.addr;
  assign net.net_cmd     = bus_q.cmd;
  assign net.net_cmd_arg = bus_q.arg;
  assign net.net_in1     = in1_q;
  assign net.net_in2     = in2_q;

  assign busy      = (state_q != ST_IDLE) || res_valid_q;
  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_time  = res_time_q;
  assign cfg_rej   = cfg_rej_q;

endmodule

// File: tb/tb_snn_trial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_trial_sequencer
// Randomised trials against a table-level reference model. A small network
// stand-in records configuration writes and counts LOAD/RUN cycles so the
// captured decision and time reveal how many entries were replayed and how
// long the run lasted.
// -----------------------------------------------------------------------------
module tb_snn_trial_sequencer;

  localparam int RC    = 37;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in1, in2;
  logic [4:0]  cfg_len;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [2:0]  cfg_addr, cfg_cmd;
  logic [7:0]  cfg_arg;
  logic        cfg_rej, busy, res_valid, res_out;
  logic [31:0] res_time;

  always #5 clk = ~clk;

  snn_trial_sequencer_if #(.ADDR_WIDTH(3), .CMD_WIDTH(3), .FLOAT_WIDTH(8)) net_if ();

  snn_trial_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .cfg_len   (cfg_len),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_cmd   (cfg_cmd),
    .cfg_arg   (cfg_arg),
    .cfg_rej   (cfg_rej),
    .busy      (busy),
    .res_valid (res_valid),
    .res_out   (res_out),
    .res_time  (res_time),
    .net       (net_if.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // ---------------- network stand-in ----------------
  logic [7:0] stub_cfg [1:7];
  int         stub_load_cnt = 0;
  int         stub_loads    = 0;
  int         stub_run      = 0;
  logic       stub_out;

  initial for (int i = 1; i <= 7; i++) stub_cfg[i] = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      stub_load_cnt <= 0;
    end else if (net_if.net_cmd == 3'd5) begin
      stub_loads    <= stub_load_cnt;
      stub_load_cnt <= 0;
      stub_run      <= 0;
    end else if (net_if.net_cmd == 3'd0) begin
      stub_run <= stub_run + 1;
    end else if (net_if.net_cmd != 3'd1 && net_if.net_addr != 3'd0) begin
      stub_cfg[net_if.net_addr] <= net_if.net_cmd_arg;
      stub_load_cnt             <= stub_load_cnt + 1;
    end
  end

  always_comb begin
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) s += int'(stub_cfg[i]);
    s += int'(net_if.net_in1) + int'(net_if.net_in2);
    stub_out = ((s % 4) == 3) ? 1'bx : s[0];
  end

  assign net_if.net_out      = stub_out;
  assign net_if.net_out_time = stub_loads * 256 + stub_run;

  // ---------------- reference model ----------------
  logic [2:0] sh_addr [DEPTH];
  logic [2:0] sh_cmd  [DEPTH];
  logic [7:0] sh_arg  [DEPTH];
  int         model_cfg [1:7];
  bit         model_dirty = 1'b1;
  int         model_last  = 0;

  initial for (int i = 1; i <= 7; i++) model_cfg[i] = 0;

  typedef struct {
    logic        out;
    logic [31:0] tm;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Which entries a trial sends, and what the network then decides.
  task automatic model_trial(int len, logic a, logic b, output exp_t e, input int e0);
    int eff, nload, s;
    eff = (len > DEPTH) ? DEPTH : len;
`ifdef SNN_SEQ_SKIP_RELOAD_EN
    if (model_dirty || eff != model_last) begin
      model_dirty = 1'b1;
      if (eff != 0) begin
        nload       = eff;
        model_dirty = 1'b0;
        model_last  = eff;
      end else begin
        nload = 0;
      end
    end else begin
      nload = 0;
    end
`else
    nload = eff;
`endif
    for (int i = 0; i < nload; i++) model_cfg[sh_addr[i]] = int'(sh_arg[i]);
    s = int'(a) + int'(b);
    for (int i = 1; i <= 7; i++) s += model_cfg[i];
    e.out = ((s % 4) == 3) ? 1'b0 : s[0];
    e.tm  = 32'(nload * 256 + RC);
    e.due = e0 + nload + 2 + RC;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res_valid: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_out", {31'd0, res_out}, {31'd0, e.out});
        check("res_time", res_time, e.tm);
        check("res_cycle", cyc, e.due);
        $display("trial result out=%0d time=%0d cycle=%0d", res_out, res_time, cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) bound_fail("wait_idle");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) bound_fail("wait_drain");
    wait_idle();
  endtask

  task automatic rand_entry(output logic [2:0] a, output logic [2:0] c, output logic [7:0] d);
    int r;
    r = int'($urandom % 4);
    a = 3'($urandom_range(1, 7));
    c = (r < 2) ? 3'(3 + r) : 3'(4 + r);
    d = 8'($urandom);
  endtask

  task automatic cfg_write(int idx);
    logic [2:0] a, c;
    logic [7:0] d;
    rand_entry(a, c, d);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_addr = a; cfg_cmd = c; cfg_arg = d;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_rej_idle_write", {31'd0, cfg_rej}, 32'd0);
    sh_addr[idx] = a; sh_cmd[idx] = c; sh_arg[idx] = d;
    model_dirty = 1'b1;
    $display("write idx=%0d addr=%0d cmd=%0d arg=%0d", idx, a, c, d);
  endtask

  // Starts a trial; with wr_too a table write is offered in the start cycle
  // and must be rejected.
  task automatic do_trial(int len, logic a, logic b, bit wr_too);
    exp_t e;
    logic [2:0] wa, wc;
    logic [7:0] wd;
    wait_idle();
    start = 1'b1; in1 = a; in2 = b; cfg_len = 5'(len);
    if (wr_too) begin
      rand_entry(wa, wc, wd);
      cfg_we = 1'b1; cfg_idx = 4'($urandom_range(0, DEPTH - 1));
      cfg_addr = wa; cfg_cmd = wc; cfg_arg = wd;
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    model_trial(len, a, b, e, cyc);
    sb.push_back(e);
    $display("start len=%0d in1=%0d in2=%0d wr=%0d E0=%0d", len, a, b, wr_too, cyc);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("net_in1_latched", {31'd0, net_if.net_in1}, {31'd0, a});
    check("net_in2_latched", {31'd0, net_if.net_in2}, {31'd0, b});
    if (wr_too) check("cfg_rej_with_start", {31'd0, cfg_rej}, 32'd1);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_rv"},    {31'd0, res_valid}, 32'd0);
    check({tag, "_rej"},   {31'd0, cfg_rej}, 32'd0);
    check({tag, "_addr"},  {29'd0, net_if.net_addr}, 32'd0);
    check({tag, "_cmd"},   {29'd0, net_if.net_cmd}, 32'd1);
    check({tag, "_arg"},   {24'd0, net_if.net_cmd_arg}, 32'd0);
    check({tag, "_in1"},   {31'd0, net_if.net_in1}, 32'd0);
    check({tag, "_in2"},   {31'd0, net_if.net_in2}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in1 = 1'b0; in2 = 1'b0; cfg_len = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_cmd = '0; cfg_arg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_res_out", {31'd0, res_out}, 32'd0);
    check("reset_res_time", res_time, 32'd0);

    for (int i = 0; i < DEPTH; i++) cfg_write(i);

    // Three entries, in1=1 in2=0.
    do_trial(3, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check_idle_outputs("after_trial");

    // Empty table replay and over-long length.
    do_trial(0, 1'b0, 1'b1, 1'b0);
    do_trial(20, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Random trials, back to back, with occasional table writes.
    for (int t = 0; t < 8; t++) begin
      wait_idle();
      if ($urandom % 2 == 0) cfg_write(int'($urandom_range(0, DEPTH - 1)));
      do_trial(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
    end
    wait_drain();

    // Write and start while running: write dropped, start ignored.
    do_trial(5, 1'b0, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    begin
      logic [2:0] a, c;
      logic [7:0] d;
      rand_entry(a, c, d);
      cfg_we = 1'b1; cfg_idx = 4'($urandom_range(0, DEPTH - 1));
      cfg_addr = a; cfg_cmd = c; cfg_arg = d;
    end
    start = 1'b1; in1 = 1'b1; in2 = 1'b1; cfg_len = 5'd2;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    check("cfg_rej_busy", {31'd0, cfg_rej}, 32'd1);
    check("busy_during_run", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("cfg_rej_one_cycle", {31'd0, cfg_rej}, 32'd0);
    wait_drain();
    do_trial(16, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Reset in the middle of LOAD.
    do_trial(16, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_dirty = 1'b1;
    $display("reset mid-load at cycle %0d", cyc);
    check_idle_outputs("midreset");
    check("midreset_res_out", {31'd0, res_out}, 32'd0);
    check("midreset_res_time", res_time, 32'd0);
    repeat (60) @(negedge clk);
    do_trial(16, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Repeat with the same length, then after a write.
    do_trial(7, 1'b1, 1'b0, 1'b0);
    do_trial(7, 1'b0, 1'b1, 1'b0);
    wait_drain();
    cfg_write(2);
    do_trial(7, 1'b1, 1'b1, 1'b0);
    wait_drain();
    check_idle_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
